mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 28, line address width.
REQ-002 Parameter LINE_W, default 128, line data width.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 proc_reset_n  input  1  asynchronous active-low reset.
REQ-005 i_read  input  1  I-cache line-fill request; held until i_ready.
REQ-006 i_addr  input  ADDR_W  I-cache line address.
REQ-007 i_rdata  output  LINE_W  fill data to I-cache.
REQ-008 i_ready  output  1  one-cycle completion strobe to I-cache.
REQ-009 d_read, d_write  input  1 each  D-cache read/write-back request; held until d_ready; never both high.
REQ-010 d_addr  input  ADDR_W  D-cache line address.
REQ-011 d_wdata  input  LINE_W  D-cache write-back data.
REQ-012 d_rdata  output  LINE_W  fill data to D-cache.
REQ-013 d_ready  output  1  one-cycle completion strobe to D-cache.
REQ-014 mem_read, mem_write  output  1 each  command to memory; held until mem_ready.
REQ-015 mem_addr  output  ADDR_W  line address to memory.
REQ-016 mem_wdata  output  LINE_W  write data to memory.
REQ-017 mem_rdata  input  LINE_W  read data, valid in the mem_ready cycle.
REQ-018 mem_ready  input  1  memory completion strobe.

Function
REQ-019 The FSM SHALL have states IDLE, BUSY, RELEASE.
REQ-020 IDLE, no request: stay IDLE; mem_read=mem_write=0.
REQ-021 IDLE, request present: grant one client, register command, address, write data and grant owner, go to BUSY next cycle.
REQ-022 Both clients requesting in IDLE: grant the client NOT granted last (round robin via last_grant flop); a single requester always wins.
REQ-023 BUSY: mem_read/mem_write/mem_addr/mem_wdata SHALL come only from registered values, stable for the whole transaction, unaffected by client input changes.
REQ-024 BUSY with mem_ready=1: assert owner's *_ready combinationally in that same cycle, update last_grant, go to RELEASE; non-owner ready stays 0.
REQ-025 i_rdata and d_rdata SHALL equal mem_rdata combinationally (pass-through); valid only while the corresponding *_ready=1.
REQ-026 BUSY with mem_ready=0: stay BUSY, no cycle limit.
REQ-027 RELEASE: command outputs 0, ignore all requests for exactly one cycle (lets the served client drop its request), then IDLE.
REQ-028 Minimum request-to-request turnaround SHALL be 3 cycles (IDLE grant, BUSY >=1, RELEASE).
REQ-029 mem_ready outside BUSY SHALL be ignored.
REQ-030 For D write-back, mem_wdata=registered d_wdata; mem_read=0, mem_write=1. For reads mem_wdata=0.
REQ-031 A pending non-granted request SHALL be granted in the next IDLE, never starved beyond one transaction.

Reset
REQ-032 proc_reset_n=0 SHALL asynchronously force state IDLE, mem_read=mem_write=0, mem_addr=0, registered wdata=0, last_grant=I (so D wins the first tie), i_ready=d_ready=0.
REQ-033 Reset asserted mid-BUSY SHALL abort the transaction with no ready strobe; after release, behaviour restarts from IDLE.
REQ-034 First grant SHALL occur no earlier than the first rising edge with proc_reset_n=1.

Verification
REQ-035 I only: i_read=1, i_addr=0x0000123, mem_ready after 4 cycles with mem_rdata=0xA5..A5 -> mem_read=1, mem_addr=0x0000123 held 4 cycles; i_ready=1 one cycle with i_rdata=0xA5..A5; d_ready=0.
REQ-036 Simultaneous after reset: i_read and d_read both 1 -> D granted first, I granted in the IDLE after RELEASE; next simultaneous tie goes to D only if I was served last.
REQ-037 Write-back: d_write=1, d_addr=0x0FFFFFF, d_wdata=0x0123..CDEF -> mem_write=1, mem_read=0, mem_wdata=0x0123..CDEF; d_ready on mem_ready.
REQ-038 Stability: change d_addr during BUSY -> mem_addr unchanged until completion.
REQ-039 Spurious mem_ready in IDLE/RELEASE -> no *_ready, no state change.
REQ-040 Reset mid-BUSY: drop proc_reset_n two cycles into a read -> mem_read=0 immediately, no i_ready/d_ready, IDLE after release.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) line arbiter in front of a single memory port.
// Latency: grant registered in IDLE, command visible next cycle, ready strobe in the mem_ready cycle.
// Backpressure: clients hold requests until their ready strobe; memory stalls by withholding mem_ready.
module mem_arbiter #(
   parameter int ADDR_W = 28,
   parameter int LINE_W = 128
) (
   input  logic              clk,
   input  logic              proc_reset_n,
   // I-cache side
   input  logic              i_read,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_ready,
   // D-cache side
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_ready,
   // memory side
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY    = 2'd1,
      RELEASE = 2'd2
   } state_t;

   // owner / last_grant encoding: 0 = I-cache, 1 = D-cache
   localparam logic GNT_I = 1'b0;
   localparam logic GNT_D = 1'b1;

   state_t              state_q, state_d;
   logic                cmd_read_q, cmd_read_d;
   logic                cmd_write_q, cmd_write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [LINE_W-1:0]   wdata_q, wdata_d;
   logic                owner_q, owner_d;
   logic                last_grant_q, last_grant_d;

   logic                d_req;
   logic                any_req;
   logic                grant_d_side;

   assign d_req   = d_read | d_write;
   assign any_req = i_read | d_req;

   // D wins when it is alone, or on a tie when I was served last.
   assign grant_d_side = d_req & (~i_read | (last_grant_q == GNT_I));

   // State and captured-command registers; reset aborts any transaction in flight.
   always_ff @(posedge clk or negedge proc_reset_n) begin
      if (!proc_reset_n) begin
         state_q      <= IDLE;
         cmd_read_q   <= 1'b0;
         cmd_write_q  <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         owner_q      <= GNT_I;
         last_grant_q <= GNT_I;
      end else begin
         state_q      <= state_d;
         cmd_read_q   <= cmd_read_d;
         cmd_write_q  <= cmd_write_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
      end
   end

   // Next-state: one grant per IDLE, wait for memory in BUSY, one dead cycle in RELEASE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_req)   state_d = BUSY;
         BUSY:    if (mem_ready) state_d = RELEASE;
         RELEASE:                state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   // Capture the winning client's command at grant; record the winner on completion.
   always_comb begin
      cmd_read_d   = cmd_read_q;
      cmd_write_d  = cmd_write_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      if (state_q == IDLE && any_req) begin
         if (grant_d_side) begin
            cmd_read_d  = d_read;
            cmd_write_d = d_write;
            addr_d      = d_addr;
            wdata_d     = d_write ? d_wdata : '0;
            owner_d     = GNT_D;
         end else begin
            cmd_read_d  = 1'b1;
            cmd_write_d = 1'b0;
            addr_d      = i_addr;
            wdata_d     = '0;
            owner_d     = GNT_I;
         end
      end
      if (state_q == BUSY && mem_ready) begin
         last_grant_d = owner_q;
      end
   end

   // Outputs: command only while BUSY, ready strobes straight from mem_ready, data passed through.
   always_comb begin
      mem_read  = (state_q == BUSY) & cmd_read_q;
      mem_write = (state_q == BUSY) & cmd_write_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      i_ready   = (state_q == BUSY) & mem_ready & (owner_q == GNT_I);
      d_ready   = (state_q == BUSY) & mem_ready & (owner_q == GNT_D);
      i_rdata   = mem_rdata;
      d_rdata   = mem_rdata;
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single requester, ties, write-back, stability,
// spurious mem_ready and reset in the middle of a transaction.
// Inputs change 1 time unit after the rising edge; outputs are checked before the next edge.
module tb_mem_arbiter;

   localparam int ADDR_W = 28;
   localparam int LINE_W = 128;

   logic              clk;
   logic              proc_reset_n;
   logic              i_read;
   logic [ADDR_W-1:0] i_addr;
   logic [LINE_W-1:0] i_rdata;
   logic              i_ready;
   logic              d_read;
   logic              d_write;
   logic [ADDR_W-1:0] d_addr;
   logic [LINE_W-1:0] d_wdata;
   logic [LINE_W-1:0] d_rdata;
   logic              d_ready;
   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_wdata;
   logic [LINE_W-1:0] mem_rdata;
   logic              mem_ready;

   int checks;
   int errors;

   mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
      .clk          (clk),
      .proc_reset_n (proc_reset_n),
      .i_read       (i_read),
      .i_addr       (i_addr),
      .i_rdata      (i_rdata),
      .i_ready      (i_ready),
      .d_read       (d_read),
      .d_write      (d_write),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_rdata      (d_rdata),
      .d_ready      (d_ready),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .mem_ready    (mem_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare one observed value against the bench's expectation.
   task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Called in an IDLE cycle with requests already driven. Runs one full
   // transaction: grant edge, nwait stalled BUSY cycles, the mem_ready cycle,
   // the RELEASE cycle (owner drops its request there), and lands in IDLE.
   task automatic txn(input string tag, input logic [ADDR_W-1:0] exp_addr,
                      input logic exp_d, input logic exp_wr,
                      input logic [LINE_W-1:0] exp_wdata, input int nwait,
                      input logic [LINE_W-1:0] rdata);
      cyc();
      for (int k = 0; k < nwait; k++) begin
         chk({tag, "_rd"},    LINE_W'(mem_read),  LINE_W'(!exp_wr));
         chk({tag, "_wr"},    LINE_W'(mem_write), LINE_W'(exp_wr));
         chk({tag, "_addr"},  LINE_W'(mem_addr),  LINE_W'(exp_addr));
         chk({tag, "_wdata"}, mem_wdata,          exp_wdata);
         chk({tag, "_rdy0"},  LINE_W'({i_ready, d_ready}), '0);
         // owner's inputs wander while BUSY; captured command must not follow
         if (exp_d) begin
            d_addr  = d_addr ^ 28'h5A5A5A5;
            d_wdata = ~d_wdata;
         end else begin
            i_addr = i_addr ^ 28'hA5A5A5A;
         end
         cyc();
      end
      mem_ready = 1'b1;
      mem_rdata = rdata;
      #1;
      chk({tag, "_addr_end"}, LINE_W'(mem_addr), LINE_W'(exp_addr));
      chk({tag, "_wdata_end"}, mem_wdata, exp_wdata);
      chk({tag, "_i_ready"},  LINE_W'(i_ready), LINE_W'(!exp_d));
      chk({tag, "_d_ready"},  LINE_W'(d_ready), LINE_W'(exp_d));
      chk({tag, "_rdata"},    exp_d ? d_rdata : i_rdata, rdata);
      cyc();
      // RELEASE: mem_ready kept high to show it is ignored here
      chk({tag, "_rel_cmd"}, LINE_W'({mem_read, mem_write}), '0);
      chk({tag, "_rel_rdy"}, LINE_W'({i_ready, d_ready}), '0);
      if (exp_d) begin
         d_read  = 1'b0;
         d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
      mem_ready = 1'b0;
      cyc();
      // IDLE: nothing issued yet even if the other client is still waiting
      chk({tag, "_idle_cmd"}, LINE_W'({mem_read, mem_write}), '0);
   endtask

   initial begin
      logic [LINE_W-1:0] pat_a5;
      logic [LINE_W-1:0] pat_wb;
      checks       = 0;
      errors       = 0;
      pat_a5       = {16{8'hA5}};
      pat_wb       = {2{64'h0123_4567_89AB_CDEF}};
      proc_reset_n = 1'b0;
      i_read       = 1'b1;
      i_addr       = 28'h0000123;
      d_read       = 1'b0;
      d_write      = 1'b0;
      d_addr       = '0;
      d_wdata      = '0;
      mem_rdata    = '0;
      mem_ready    = 1'b1;

      // Reset state, with a request and mem_ready already present
      cyc(); cyc(); cyc();
      chk("rst_mem_read",  LINE_W'(mem_read),  '0);
      chk("rst_mem_write", LINE_W'(mem_write), '0);
      chk("rst_mem_addr",  LINE_W'(mem_addr),  '0);
      chk("rst_mem_wdata", mem_wdata,          '0);
      chk("rst_ready",     LINE_W'({i_ready, d_ready}), '0);
      mem_ready    = 1'b0;
      proc_reset_n = 1'b1;
      #1;
      chk("post_rst_no_grant", LINE_W'(mem_read), '0);

      // I only: 4 BUSY cycles, ready in the 4th
      txn("i_only", 28'h0000123, 1'b0, 1'b0, '0, 3, pat_a5);

      // Tie right after reset: D first, then I in the very next IDLE
      proc_reset_n = 1'b0;
      cyc(); cyc();
      i_read = 1'b1; i_addr = 28'h0000111;
      d_read = 1'b1; d_addr = 28'h0000222;
      proc_reset_n = 1'b1;
      txn("tie1_d", 28'h0000222, 1'b1, 1'b0, '0, 0, {4{32'h1111_2222}});
      txn("tie1_i", 28'h0000111, 1'b0, 1'b0, '0, 1, {4{32'h3333_4444}});

      // I served last: next tie goes to D, then the waiting I
      i_read = 1'b1; i_addr = 28'h0000333;
      d_read = 1'b1; d_addr = 28'h0000444;
      txn("tie2_d", 28'h0000444, 1'b1, 1'b0, '0, 2, {4{32'hDEAD_BEEF}});
      txn("tie2_i", 28'h0000333, 1'b0, 1'b0, '0, 0, {4{32'hCAFE_F00D}});

      // Write-back with d_addr/d_wdata disturbed mid-transaction
      d_write = 1'b1; d_addr = 28'h0FFFFFF; d_wdata = pat_wb;
      txn("wb", 28'h0FFFFFF, 1'b1, 1'b1, pat_wb, 3, '0);

      // Spurious mem_ready while IDLE: no strobes, no command
      mem_ready = 1'b1;
      #1;
      chk("spur_idle_rdy", LINE_W'({i_ready, d_ready}), '0);
      cyc();
      chk("spur_idle_cmd", LINE_W'({mem_read, mem_write}), '0);
      chk("spur_idle_rdy2", LINE_W'({i_ready, d_ready}), '0);
      mem_ready = 1'b0;

      // D served last: tie now goes to I
      i_read = 1'b1; i_addr = 28'h0000555;
      d_read = 1'b1; d_addr = 28'h0000666;
      txn("tie3_i", 28'h0000555, 1'b0, 1'b0, '0, 0, {4{32'h0F0F_0F0F}});
      txn("tie3_d", 28'h0000666, 1'b1, 1'b0, '0, 0, {4{32'hF0F0_F0F0}});

      // Reset two cycles into a read: command drops at once, no strobe
      i_read = 1'b1; i_addr = 28'h0000777;
      cyc();
      chk("mid_busy_rd", LINE_W'(mem_read), 1);
      cyc();
      mem_ready    = 1'b1;
      proc_reset_n = 1'b0;
      #1;
      chk("mid_rst_rd",   LINE_W'(mem_read), '0);
      chk("mid_rst_addr", LINE_W'(mem_addr), '0);
      chk("mid_rst_rdy",  LINE_W'({i_ready, d_ready}), '0);
      i_read    = 1'b0;
      mem_ready = 1'b0;
      cyc();
      proc_reset_n = 1'b1;
      cyc();
      chk("after_rst_idle", LINE_W'({mem_read, mem_write}), '0);

      // After that reset last_grant is I again, so D wins the tie
      i_read = 1'b1; i_addr = 28'h0000888;
      d_read = 1'b1; d_addr = 28'h0000999;
      txn("tie4_d", 28'h0000999, 1'b1, 1'b0, '0, 1, {4{32'h1234_5678}});
      txn("tie4_i", 28'h0000888, 1'b0, 1'b0, '0, 0, {4{32'h8765_4321}});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
